// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadows the E/M/W destination records of the 5-stage
// pipeline, raises the D-stage stall and drives the D/E forward selects.
// Build option: define HAZARD_FWD_EN for the forwarding build; without it the
// block is stall-only (Tnew ignored, forward selects tied to 0).
// Sync interface: no handshakes; every output is a pure function of the
// registered slots and the current D-stage inputs, updated each rising Clk.
module hazard_scoreboard #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [4:0]        D_A1,
  input  logic [4:0]        D_A2,
  input  logic [TNEW_W-1:0] D_Tuse_rs,
  input  logic [TNEW_W-1:0] D_Tuse_rt,
  input  logic [4:0]        D_A3,
  input  logic              D_RFWr,
  input  logic [TNEW_W-1:0] D_Tnew,
  output logic              Stall,
  output logic [1:0]        D_FwdA,
  output logic [1:0]        D_FwdB,
  output logic [1:0]        E_FwdA,
  output logic [1:0]        E_FwdB,
  output logic [CNT_W-1:0]  StallCnt
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Tuse of all-ones means the operand is never read.
  localparam logic [TNEW_W-1:0] TUSE_NEVER = '1;

  typedef struct packed {
    logic              vld;
    logic [4:0]        a1;
    logic [4:0]        a2;
    logic [4:0]        a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } e_slot_t;

  typedef struct packed {
    logic              vld;
    logic [4:0]        a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } m_slot_t;

  // W results always exist, so the W record carries no Tnew.
  typedef struct packed {
    logic       vld;
    logic [4:0] a3;
    logic       we;
  } w_slot_t;

  e_slot_t          e_q, e_d;
  m_slot_t          m_q, m_d;
  w_slot_t          w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic e_live, m_live, w_live;
  logic stall_c;

  logic [1:0][4:0]        d_src;
  logic [1:0][TNEW_W-1:0] d_tuse;
  logic [1:0][4:0]        e_src;
  logic [1:0]             d_e_hit, d_m_hit, e_m_hit, e_w_hit;
  logic [1:0][1:0]        d_fwd, e_fwd;

  assign e_live = e_q.vld & e_q.we & (e_q.a3 != 5'd0);
  assign m_live = m_q.vld & m_q.we & (m_q.a3 != 5'd0);
  assign w_live = w_q.vld & w_q.we & (w_q.a3 != 5'd0);

  assign d_src  = {D_A2, D_A1};
  assign d_tuse = {D_Tuse_rt, D_Tuse_rs};
  assign e_src  = {e_q.a2, e_q.a1};

  // Register-number matches of each source against the live writer slots.
  always_comb begin : hit_detect
    d_e_hit = '0;
    d_m_hit = '0;
    e_m_hit = '0;
    e_w_hit = '0;
    for (int i = 0; i < 2; i++) begin
      d_e_hit[i] = e_live && (d_src[i] != 5'd0) && (e_q.a3 == d_src[i]);
      d_m_hit[i] = m_live && (d_src[i] != 5'd0) && (m_q.a3 == d_src[i]);
      e_m_hit[i] = e_q.vld && m_live && (e_src[i] != 5'd0) && (m_q.a3 == e_src[i]);
      e_w_hit[i] = e_q.vld && w_live && (e_src[i] != 5'd0) && (w_q.a3 == e_src[i]);
    end
  end

  // Stall and forward selects; a younger E writer always shadows an older M one.
  always_comb begin : hazard_logic
    stall_c = 1'b0;
    d_fwd   = '0;
    e_fwd   = '0;
    for (int i = 0; i < 2; i++) begin
      if (FWD_EN) begin
        if (d_e_hit[i]) begin
          if (e_q.tnew > d_tuse[i]) stall_c = 1'b1;
          if (e_q.tnew == '0) d_fwd[i] = 2'd2;
        end else if (d_m_hit[i]) begin
          if (m_q.tnew > d_tuse[i]) stall_c = 1'b1;
          if (m_q.tnew == '0) d_fwd[i] = 2'd1;
        end
        if (e_m_hit[i] && (m_q.tnew == '0)) e_fwd[i] = 2'd1;
        else if (e_w_hit[i])                e_fwd[i] = 2'd2;
      end else begin
        if ((d_e_hit[i] || d_m_hit[i]) && (d_tuse[i] != TUSE_NEVER)) stall_c = 1'b1;
      end
    end
  end

  // Pipeline advance of the shadow records and the saturating stall counter.
  always_comb begin : next_state
    if (stall_c) begin
      e_d = '0;
    end else begin
      e_d = '{vld: 1'b1, a1: D_A1, a2: D_A2, a3: D_A3, we: D_RFWr, tnew: D_Tnew};
    end
    m_d.vld  = e_q.vld;
    m_d.a3   = e_q.a3;
    m_d.we   = e_q.we;
    m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - 1'b1;
    w_d.vld  = m_q.vld;
    w_d.a3   = m_q.a3;
    w_d.we   = m_q.we;
    cnt_d    = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset empties every slot and clears the counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign Stall    = stall_c;
  assign D_FwdA   = d_fwd[0];
  assign D_FwdB   = d_fwd[1];
  assign E_FwdA   = e_fwd[0];
  assign E_FwdB   = e_fwd[1];
  assign StallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven vectors for hazard_scoreboard, with the
// expected {Stall, D_FwdA, D_FwdB, E_FwdA, E_FwdB} and StallCnt per cycle.
// Tables follow HAZARD_FWD_EN so the bench matches either build.
module tb_hazard_scoreboard;

  localparam int TNEW_W = 2;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [4:0]        D_A1, D_A2, D_A3;
  logic [TNEW_W-1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic              D_RFWr;
  logic              Stall;
  logic [1:0]        D_FwdA, D_FwdB, E_FwdA, E_FwdB;
  logic [CNT_W-1:0]  StallCnt;

  hazard_scoreboard #(.TNEW_W(TNEW_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_A3(D_A3), .D_RFWr(D_RFWr), .D_Tnew(D_Tnew),
    .Stall(Stall), .D_FwdA(D_FwdA), .D_FwdB(D_FwdB),
    .E_FwdA(E_FwdA), .E_FwdB(E_FwdB), .StallCnt(StallCnt)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [4:0] a1, a2, a3;
    logic [1:0] tu_rs, tu_rt, tnew;
    logic       we;
    logic [8:0] exp;
  } vec_t;

  vec_t             vecs[$];
  logic [8:0]       exp_q[$];
  logic [8:0]       want, got;
  logic [CNT_W-1:0] exp_cnt;
  int               n_applied = 0;
  int               n_miss    = 0;

  // Append one cycle: inputs, then expected stall/dfa/dfb/efa/efb.
  task automatic v(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                   input logic [1:0] tr, input logic [1:0] tt, input logic [4:0] a3,
                   input logic we, input logic [1:0] tn, input logic st,
                   input logic [1:0] dfa, input logic [1:0] dfb,
                   input logic [1:0] efa, input logic [1:0] efb);
    vec_t t;
    t.rst = r; t.a1 = a1; t.a2 = a2; t.tu_rs = tr; t.tu_rt = tt;
    t.a3 = a3; t.we = we; t.tnew = tn;
    t.exp = {st, dfa, dfb, efa, efb};
    vecs.push_back(t);
  endtask

  // lw $9 followed by a Tuse=0 reader: two stall cycles per block in both builds.
  task automatic sat_block();
    v(0, 0, 0, 3, 3, 9, 1, 2, 0, 0, 0, 0, 0);
    v(0, 9, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 9, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_tables();
    // Reset for two cycles, then idle.
    v(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    // lw $1 (Tnew=2); add $2,$1,$3 (Tuse=1): one stall, then E_FwdA=2 from W.
    v(0, 29, 0, 1, 3, 1, 1, 2, 0, 0, 0, 0, 0);
    v(0, 1, 3, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    v(0, 1, 3, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    v(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2, 0);
    // ori $1 (Tnew=1); beq $1,$0 (Tuse=0): one stall, then D_FwdA=1.
    v(0, 4, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // jal; jr $31: no stall, D_FwdA=2. beq in E sees ori in W.
    v(0, 0, 0, 3, 3, 31, 1, 0, 0, 0, 0, 2, 0);
    v(0, 31, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0);
    // Writers to $0 then reader of $0; jr in E sees jal in M.
    v(0, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 3, 3, 0, 1, 2, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    // Two writers of $6 back to back: E (not ready) shadows M (ready).
    v(0, 0, 0, 3, 3, 6, 1, 0, 0, 0, 0, 0, 0);
    v(0, 5, 0, 1, 3, 6, 1, 1, 0, 1, 0, 0, 0);
    v(0, 6, 6, 0, 0, 7, 1, 0, 1, 0, 0, 2, 0);
    v(0, 6, 6, 0, 0, 7, 1, 0, 0, 1, 1, 0, 0);
    // lw $8 then ready writer $8: E governs, no stall even though M is late.
    v(0, 0, 0, 3, 3, 8, 1, 2, 0, 0, 0, 2, 2);
    v(0, 0, 0, 3, 3, 8, 1, 0, 0, 0, 0, 0, 0);
    v(0, 8, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0);
    v(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    // Reset during a stall with lw in E.
    v(0, 0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0);
    v(1, 1, 0, 1, 3, 2, 1, 1, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, 3, 2, 1, 1, 0, 0, 0, 0, 0);
`else
    // ori $1; beq $1: two stall cycles, forwards stay 0.
    v(0, 4, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Matching source with Tuse=3 never stalls.
    v(0, 0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    // Ready writer $5 still stalls an rt reader (Tnew ignored).
    v(0, 0, 0, 3, 3, 5, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 5, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 5, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 5, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    // Writer to $0 then reader of $0.
    v(0, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Reset during a stall.
    v(0, 0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    // Enough stalls to saturate the 4-bit counter.
    for (int b = 0; b < 9; b++) sat_block();
`ifdef HAZARD_FWD_EN
    // Tuse equal to Tnew is not a stall; a late M writer is.
    v(0, 0, 0, 3, 3, 10, 1, 2, 0, 0, 0, 0, 0);
    v(0, 0, 10, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 10, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 10, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
  endtask

  // Driver, scoreboard and final report.
  initial begin
    Rst = 1'b1;
    D_A1 = '0; D_A2 = '0; D_A3 = '0; D_RFWr = 1'b0;
    D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_Tnew = '0;
    exp_cnt = '0;
    fill_tables();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      Rst = vecs[i].rst;
      D_A1 = vecs[i].a1; D_A2 = vecs[i].a2; D_A3 = vecs[i].a3;
      D_Tuse_rs = vecs[i].tu_rs; D_Tuse_rt = vecs[i].tu_rt;
      D_RFWr = vecs[i].we; D_Tnew = vecs[i].tnew;
      if (!vecs[i].rst) exp_q.push_back(vecs[i].exp);
      #2;
      if (!vecs[i].rst) begin
        want = exp_q.pop_front();
        got  = {Stall, D_FwdA, D_FwdB, E_FwdA, E_FwdB};
        n_applied++;
        if (got !== want) begin
          n_miss++;
          $display("FAIL vec %0d stall/dfa/dfb/efa/efb: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                   i, got[8], got[7:6], got[5:4], got[3:2], got[1:0],
                   want[8], want[7:6], want[5:4], want[3:2], want[1:0]);
        end
        n_applied++;
        if (StallCnt !== exp_cnt) begin
          n_miss++;
          $display("FAIL vec %0d StallCnt: got %0d want %0d", i, StallCnt, exp_cnt);
        end
        if (want[8] && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
      end else begin
        exp_cnt = '0;
      end
    end
    @(negedge Clk);
    n_applied++;
    if (StallCnt !== exp_cnt) begin
      n_miss++;
      $display("FAIL final StallCnt: got %0d want %0d", StallCnt, exp_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
